// File: rtl/mac_seq_divider.sv
// mac_seq_divider: sequential restoring divider, one quotient bit per clock.
// Unsigned DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor -> quotient and remainder,
// with valid/ready handshakes on both the operand and result sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor    unsigned operands, sampled on the accept edge
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   quotient, remainder  result; all-ones / dividend LSBs for a zero divisor
//   div_by_zero          result came from a zero divisor
//   busy                 high while iterating
module mac_seq_divider #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DIVIDEND_W + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(DIVIDEND_W);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    // The partial remainder is always < divisor between iterations, so its extra
    // (DIVISOR_W+1)th bit is zero and only exists inside the shifted value p_shift.
    logic [DIVISOR_W-1:0]  p_q, p_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    p_shift;
    logic [DIVISOR_W-1:0]  p_sub;
    logic                  ge;

    always_comb begin
        p_shift = {p_q, q_q[DIVIDEND_W-1]};
        ge      = (p_shift >= {1'b0, d_q});
        // When ge holds the true difference is < divisor, so the low bits suffice.
        p_sub   = p_shift[DIVISOR_W-1:0] - d_q;
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        p_d     = p_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    d_d = divisor;
                    if (divisor != '0) begin
                        q_d     = dividend;
                        p_d     = '0;
                        cnt_d   = CntInit;
                        dbz_d   = 1'b0;
                        state_d = StCalc;
                    end else begin
                        q_d     = '1;
                        p_d     = dividend[DIVISOR_W-1:0];
                        cnt_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                q_d    = q_q << 1;
                q_d[0] = ge;
                p_d    = ge ? p_sub : p_shift[DIVISOR_W-1:0];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            p_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            p_q     <= p_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q == StCalc);
    assign out_valid   = (state_q == StDone);
    assign quotient    = q_q;
    assign remainder   = p_q;
    assign div_by_zero = dbz_q;

endmodule
